atomrv_fetch_buffer: RTL
========================

Name: atomrv_fetch_buffer

Overview:
Parametrised instruction-fetch unit with a prefetch queue. It generates sequential fetch addresses and issues them to instruction memory over a request/grant handshake. Returned words are buffered with their PCs in a DEPTH-entry FIFO and handed to decode over a valid/ready handshake. Branch/JAL/JALR redirects flush the queue and squash in-flight responses.

Parameters:
DATAWIDTH, 32, PC and instruction width
DEPTH, 4, prefetch FIFO entries; power of two, >=2
RESET_PC, 32'h0000_0000, first fetch address after reset

Ports:
clk_i  in  1  clock, rising edge
PCrst_i  in  1  reset, asynchronous, active-low
imem_req_o  out  1  fetch request valid
imem_addr_o  out  DATAWIDTH  fetch address, word aligned
imem_gnt_i  in  1  memory accepts request this cycle
imem_rvalid_i  in  1  response valid; in order, >=1 cycle after grant
imem_rdata_i  in  DATAWIDTH  response instruction word
br_en_i  in  1  taken branch redirect
jal_en_i  in  1  JAL redirect
jalr_en_i  in  1  JALR redirect
pc_ex_i  in  DATAWIDTH  PC of redirecting instruction
rs1_i  in  DATAWIDTH  rs1 value for JALR
imm_i  in  DATAWIDTH  byte-offset immediate, sign-extended
instr_valid_o  out  1  FIFO head valid
instr_ready_i  in  1  decode accepts head
instr_o  out  DATAWIDTH  head instruction
pc_o  out  DATAWIDTH  head PC
link_o  out  DATAWIDTH  pc_ex_i+4, combinational, for rd write
misalign_o  out  1  one-cycle pulse: redirect target bit[1] set
fetch_cnt_o  out  32  instructions delivered (optional feature)
flush_cnt_o  out  32  redirects taken (optional feature)

Behaviour:
- Reset (PCrst_i=0, async): fetch_pc=resp_pc=RESET_PC; FIFO empty; outstanding=0; discard=0; imem_req_o=0; instr_valid_o=0; misalign_o=0; counters=0. pc_o/instr_o are 0 while empty.
- redirect = br_en_i|jal_en_i|jalr_en_i. Priority: jalr_en_i > (br_en_i|jal_en_i).
- Target: jalr ? (rs1_i+imm_i) with bit0 cleared : pc_ex_i+imm_i. Modulo 2^DATAWIDTH wrap.
- Applied target has bits[1:0]=0. misalign_o=1 in the cycle after a redirect whose raw target[1]=1.
- Issue: imem_req_o = !redirect && (outstanding+count < DEPTH). imem_addr_o = fetch_pc.
- On req&gnt: fetch_pc += 4 (wraps) and outstanding++.
- Response: rvalid decrements outstanding.
  - If discard>0: word is dropped and discard--.
  - Otherwise {resp_pc, rdata} is pushed and resp_pc += 4.
  - Push can never overflow by construction; assert this in simulation.
- Output: instr_valid_o = !empty. Pop on instr_valid_o & instr_ready_i. Push and pop in the same cycle are both performed.
- Redirect cycle:
  - fetch_pc and resp_pc are set to target; FIFO is cleared.
  - Any pop that cycle counts as consumed, but the FIFO still ends empty.
  - discard = outstanding after this cycle's grant/response accounting, excluding any response dropped or pushed this cycle.
  - No request is issued during redirect. Fetch resumes the next cycle at target.
- Steady state with 1-cycle memory and ready decode: one instruction per cycle; first valid 2 cycles after reset release.
- Back-to-back redirects: the last one wins; discard accumulates correctly.
- Reset mid-operation: all state clears immediately; late memory responses after reset are not guarded; the memory is reset together with this block.

Optional Feature:
Macro FETCH_PERF_CNT_EN.
- Defined: fetch_cnt_o increments on each pop; flush_cnt_o increments on each redirect. Both are 32-bit wrapping and reset to 0.
- Undefined: both ports are tied to 0 and no counter flops exist.

Test Plan:
- Reset release, gnt=1, 1-cycle rvalid, ready=1 -> imem_addr_o 0,4,8,...; pc_o 0,4,8 on consecutive cycles; first instr_valid_o 2 cycles after release.
- instr_ready_i=0, memory always grants -> exactly 4 requests issued (DEPTH=4), then imem_req_o=0. On ready=1, PCs 0..12 drain in order and fetch resumes at 16.
- Memory latency 3, 2 requests outstanding, br_en_i with pc_ex_i=8, imm_i=0x20 -> both stale responses dropped; next pc_o=0x28; FIFO held nothing stale.
- jalr_en_i with rs1_i=0x101, imm_i=4 -> fetch at 0x104, misalign_o=0. With rs1_i=0x102 -> misalign_o pulses, fetch at 0x104.
- jal_en_i and jalr_en_i together (rs1_i=0x200, imm_i=0, pc_ex_i=0x40) -> target 0x200; link_o=0x44.
- With FETCH_PERF_CNT_EN, run 10 delivered instructions and 2 redirects -> fetch_cnt_o=10, flush_cnt_o=2. PCrst_i pulse mid-run -> all outputs 0 asynchronously, restart at RESET_PC.

Source files
------------

// File: rtl/atomrv_fetch_buffer.sv
// rtl/atomrv_fetch_buffer.sv - instruction fetch unit with prefetch FIFO and redirect flush
// Optional feature macro: FETCH_PERF_CNT_EN (delivered-instruction and redirect counters).
module atomrv_fetch_buffer #(
  parameter int                   DATAWIDTH = 32,
  parameter int                   DEPTH     = 4,
  parameter logic [DATAWIDTH-1:0] RESET_PC  = '0
) (
  input  logic                 clk_i,
  input  logic                 PCrst_i,
  output logic                 imem_req_o,
  output logic [DATAWIDTH-1:0] imem_addr_o,
  input  logic                 imem_gnt_i,
  input  logic                 imem_rvalid_i,
  input  logic [DATAWIDTH-1:0] imem_rdata_i,
  input  logic                 br_en_i,
  input  logic                 jal_en_i,
  input  logic                 jalr_en_i,
  input  logic [DATAWIDTH-1:0] pc_ex_i,
  input  logic [DATAWIDTH-1:0] rs1_i,
  input  logic [DATAWIDTH-1:0] imm_i,
  output logic                 instr_valid_o,
  input  logic                 instr_ready_i,
  output logic [DATAWIDTH-1:0] instr_o,
  output logic [DATAWIDTH-1:0] pc_o,
  output logic [DATAWIDTH-1:0] link_o,
  output logic                 misalign_o,
  output logic [31:0]          fetch_cnt_o,
  output logic [31:0]          flush_cnt_o
);

  localparam int PTRW = $clog2(DEPTH);
  localparam int CNTW = PTRW + 1;
  localparam int SUMW = PTRW + 2;

  // Program counters: fetch_pc tracks the next request, resp_pc the next response.
  logic [DATAWIDTH-1:0] r_fetch_pc;
  logic [DATAWIDTH-1:0] r_resp_pc;

  // FIFO storage and bookkeeping; storage has no reset, only pointers do.
  logic [DATAWIDTH-1:0] r_fifo_instr [DEPTH];
  logic [DATAWIDTH-1:0] r_fifo_pc    [DEPTH];
  logic [PTRW-1:0]      r_wptr;
  logic [PTRW-1:0]      r_rptr;
  logic [CNTW-1:0]      r_count;

  // Requests granted but not yet answered, and how many of those are stale.
  logic [CNTW-1:0]      r_outstanding;
  logic [CNTW-1:0]      r_discard;
  logic                 r_misalign;

  logic                 w_redirect;
  logic [DATAWIDTH-1:0] w_jalr_sum;
  logic [DATAWIDTH-1:0] w_raw_target;
  logic [DATAWIDTH-1:0] w_target;
  logic [SUMW-1:0]      w_inflight;
  logic                 w_issue_ok;
  logic                 w_grant;
  logic                 w_pop;
  logic                 w_drop;
  logic                 w_push;
  logic [CNTW-1:0]      w_outstanding_nxt;

  // JALR outranks branch/JAL; the applied target is always word aligned,
  // while bit 1 of the raw target is remembered for the misalign pulse.
  assign w_redirect   = br_en_i | jal_en_i | jalr_en_i;
  assign w_jalr_sum   = rs1_i + imm_i;
  assign w_raw_target = jalr_en_i ? (w_jalr_sum & ~DATAWIDTH'(1)) : (pc_ex_i + imm_i);
  assign w_target     = w_raw_target & ~DATAWIDTH'(3);
  assign link_o       = pc_ex_i + DATAWIDTH'(4);

  // Only issue when the FIFO is guaranteed room for every in-flight response.
  assign w_inflight   = SUMW'(r_outstanding) + SUMW'(r_count);
  assign w_issue_ok   = w_inflight < SUMW'(DEPTH);
  assign imem_req_o   = PCrst_i & ~w_redirect & w_issue_ok;
  assign imem_addr_o  = r_fetch_pc;
  assign w_grant      = imem_req_o & imem_gnt_i;

  assign instr_valid_o = (r_count != '0);
  assign w_pop         = instr_valid_o & instr_ready_i;
  assign instr_o       = instr_valid_o ? r_fifo_instr[r_rptr] : '0;
  assign pc_o          = instr_valid_o ? r_fifo_pc[r_rptr]    : '0;

  // A response in a redirect cycle belongs to the old stream and is neither
  // pushed nor counted as stale, since it retires this cycle.
  assign w_drop            = imem_rvalid_i & (r_discard != '0);
  assign w_push            = imem_rvalid_i & (r_discard == '0) & ~w_redirect;
  assign w_outstanding_nxt = r_outstanding + CNTW'(w_grant) - CNTW'(imem_rvalid_i);

  assign misalign_o = r_misalign;

  // Control state: PCs, FIFO pointers, outstanding/discard accounting, misalign pulse.
  always_ff @(posedge clk_i or negedge PCrst_i) begin
    if (!PCrst_i) begin
      r_fetch_pc    <= RESET_PC;
      r_resp_pc     <= RESET_PC;
      r_wptr        <= '0;
      r_rptr        <= '0;
      r_count       <= '0;
      r_outstanding <= '0;
      r_discard     <= '0;
      r_misalign    <= 1'b0;
    end else begin
      r_outstanding <= w_outstanding_nxt;
      r_misalign    <= w_redirect & w_raw_target[1];
      if (w_redirect) begin
        r_fetch_pc <= w_target;
        r_resp_pc  <= w_target;
        r_wptr     <= '0;
        r_rptr     <= '0;
        r_count    <= '0;
        r_discard  <= w_outstanding_nxt;
      end else begin
        if (w_grant) begin
          r_fetch_pc <= r_fetch_pc + DATAWIDTH'(4);
        end
        if (w_drop) begin
          r_discard <= r_discard - CNTW'(1);
        end
        if (w_push) begin
          r_wptr    <= r_wptr + PTRW'(1);
          r_resp_pc <= r_resp_pc + DATAWIDTH'(4);
        end
        if (w_pop) begin
          r_rptr <= r_rptr + PTRW'(1);
        end
        r_count <= r_count + CNTW'(w_push) - CNTW'(w_pop);
      end
    end
  end

  // FIFO storage write: instruction word tagged with the PC it was fetched from.
  always_ff @(posedge clk_i) begin
    if (w_push) begin
      r_fifo_instr[r_wptr] <= imem_rdata_i;
      r_fifo_pc[r_wptr]    <= r_resp_pc;
    end
  end

  // The issue throttle makes a push into a full FIFO impossible.
  always_ff @(posedge clk_i) begin
    if (PCrst_i) begin
      assert (!(w_push && (r_count == CNTW'(DEPTH))));
    end
  end

`ifdef FETCH_PERF_CNT_EN
  logic [31:0] r_fetch_cnt;
  logic [31:0] r_flush_cnt;

  // Wrapping counters of delivered instructions and taken redirects.
  always_ff @(posedge clk_i or negedge PCrst_i) begin
    if (!PCrst_i) begin
      r_fetch_cnt <= '0;
      r_flush_cnt <= '0;
    end else begin
      if (w_pop) begin
        r_fetch_cnt <= r_fetch_cnt + 32'd1;
      end
      if (w_redirect) begin
        r_flush_cnt <= r_flush_cnt + 32'd1;
      end
    end
  end

  assign fetch_cnt_o = r_fetch_cnt;
  assign flush_cnt_o = r_flush_cnt;
`else
  assign fetch_cnt_o = '0;
  assign flush_cnt_o = '0;
`endif

endmodule
